// File: rtl/fetch_pkg.sv
// Shared fetch types and constants.
// State enum, default halt word, PC and I-mem address widths.
package fetch_pkg;

    localparam int PC_W    = 32;
    localparam int IMEM_AW = 8;

    localparam logic [PC_W-1:0] HALT_INST_DEF = 32'h0000_000C;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT,
        ST_FAULT
    } fetch_state_e;

    // Word-aligned and inside the 1 KiB instruction memory.
    function automatic logic pc_bad(input logic [PC_W-1:0] pc);
        return (pc[PC_W-1:IMEM_AW+2] != '0) || (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_npc.sv
// Next-PC select: jr > jump > branch > sequential.
// In: pc, pc4 of inst_o, valid, stall, redirects. Out: next_pc, redirect.
module fetch_npc
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] pc4,
    input  logic            valid,
    input  logic            stall,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_addr,
    input  logic            jump,
    input  logic [25:0]     jump_target,
    input  logic            branch_taken,
    input  logic [15:0]     branch_off,
    output logic [PC_W-1:0] next_pc,
    output logic            redirect
);

    logic            take;
    logic [PC_W-1:0] br_tgt;

    assign take   = valid && !stall;
    assign br_tgt = pc4 + {{14{branch_off[15]}}, branch_off, 2'b00};

    always_comb begin
        next_pc  = pc + 32'd4;
        redirect = 1'b0;
        if (take) begin
            unique case (1'b1)
                jr: begin
                    next_pc  = jr_addr;
                    redirect = 1'b1;
                end
                (!jr && jump): begin
                    next_pc  = {pc4[31:28], jump_target, 2'b00};
                    redirect = 1'b1;
                end
                (!jr && !jump && branch_taken): begin
                    next_pc  = br_tgt;
                    redirect = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, output register, BOOT/RUN/HALT/FAULT.
// I-mem read via addrrd_o/inst_i; decode gets inst_o/pc_o/pc4_o/valid_o.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [PC_W-1:0] HALT_INST = HALT_INST_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [15:0]        branch_off_i,
    input  logic               jump_i,
    input  logic [25:0]        jump_target_i,
    input  logic               jr_i,
    input  logic [PC_W-1:0]    jr_addr_i,
    input  logic [PC_W-1:0]    inst_i,
    output logic [IMEM_AW-1:0] addrrd_o,
    output logic [PC_W-1:0]    inst_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [PC_W-1:0]    pc4_o,
    output logic               valid_o,
    output logic               halted_o,
    output logic               addr_err_o
);

    fetch_state_e    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic            redirect;

    assign addrrd_o = pc[IMEM_AW+1:2];

    fetch_npc u_npc (
        .pc           (pc),
        .pc4          (pc4_o),
        .valid        (valid_o),
        .stall        (stall_i),
        .jr           (jr_i),
        .jr_addr      (jr_addr_i),
        .jump         (jump_i),
        .jump_target  (jump_target_i),
        .branch_taken (branch_taken_i),
        .branch_off   (branch_off_i),
        .next_pc      (next_pc),
        .redirect     (redirect)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_BOOT;
            pc         <= RESET_PC;
            inst_o     <= '0;
            pc_o       <= '0;
            pc4_o      <= '0;
            valid_o    <= 1'b0;
            halted_o   <= 1'b0;
            addr_err_o <= 1'b0;
        end else begin
            unique case (state)
                ST_BOOT: begin
                    state   <= ST_RUN;
                    valid_o <= 1'b0;
                end
                ST_RUN: begin
                    if (!stall_i) begin
                        if (pc_bad(pc)) begin
                            state      <= ST_FAULT;
                            valid_o    <= 1'b0;
                            addr_err_o <= 1'b1;
                        end else if (redirect) begin
                            // No delay slot: drop this cycle's fetch.
                            valid_o <= 1'b0;
                            pc      <= next_pc;
                        end else begin
                            inst_o  <= inst_i;
                            pc_o    <= pc;
                            pc4_o   <= pc + 32'd4;
                            valid_o <= 1'b1;
                            pc      <= next_pc;
                            if (inst_i == HALT_INST) begin
                                state    <= ST_HALT;
                                halted_o <= 1'b1;
                            end
                        end
                    end
                end
                ST_HALT, ST_FAULT: begin
                    valid_o <= 1'b0;
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule
